// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 24-bit hybrid adder among NUM_REQ requesters.
// Results land in a one-entry registered slot with backpressure, tagged by requester ID.

module approximate_adder (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        cin,
  output logic [23:0] sum,
  output logic        carry_out
);
  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] carry_s;

  // Upper byte: flattened lookahead carries; lower 16 bits: OR sum, AND-of-MSB carry.
  always_comb begin
    gen_s   = a[23:16] & b[23:16];
    prop_s  = a[23:16] ^ b[23:16];
    carry_s = 9'd0;
    carry_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      logic term_v;
      logic prod_v;
      term_v = gen_s[i];
      prod_v = prop_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_v = term_v | (prod_v & gen_s[j]);
        prod_v = prod_v & prop_s[j];
      end
      carry_s[i+1] = term_v | (prod_v & cin);
    end
    sum       = {prop_s ^ carry_s[7:0], a[15:0] | b[15:0]};
    carry_out = carry_s[8] | (a[15] & b[15]);
  end
endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*24-1:0] req_a,
  input  logic [NUM_REQ*24-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [23:0]           res_sum,
  output logic                  res_cout,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      op_count
);
  logic [ID_W-1:0]    ptr_r;
  logic               res_valid_r;
  logic [23:0]        res_sum_r;
  logic               res_cout_r;
  logic [ID_W-1:0]    res_id_r;
  logic [CNT_W-1:0]   op_count_r;

  logic [ID_W-1:0]    grant_id_s;
  logic               grant_valid_s;
  logic               out_free_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [23:0]        add_a_s;
  logic [23:0]        add_b_s;
  logic               add_cin_s;
  logic [23:0]        add_sum_s;
  logic               add_cout_s;

  assign out_free_s = !res_valid_r || res_ready;
  assign accept_s   = grant_valid_s && out_free_s;

  // Round-robin search starting at ptr_r; first valid requester wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W:0] cand_v;
      logic [ID_W:0] wrap_v;
      cand_v = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (cand_v >= (ID_W+1)'(NUM_REQ)) begin
        wrap_v = cand_v - (ID_W+1)'(NUM_REQ);
      end else begin
        wrap_v = cand_v;
      end
      if (!grant_valid_s && req_valid[wrap_v[ID_W-1:0]]) begin
        grant_valid_s = 1'b1;
        grant_id_s    = wrap_v[ID_W-1:0];
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Operand mux into the shared adder plus one-hot ready; zeros when nothing is granted.
  always_comb begin
    add_a_s     = 24'd0;
    add_b_s     = 24'd0;
    add_cin_s   = 1'b0;
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid_s && (grant_id_s == ID_W'(i))) begin
        add_a_s        = req_a[24*i +: 24];
        add_b_s        = req_b[24*i +: 24];
        add_cin_s      = req_cin[i];
        req_ready_s[i] = rst_n && out_free_s;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  approximate_adder u_adder (
    .a         (add_a_s),
    .b         (add_b_s),
    .cin       (add_cin_s),
    .sum       (add_sum_s),
    .carry_out (add_cout_s)
  );

  // Result slot, rotation pointer and operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      res_valid_r <= 1'b0;
      res_sum_r   <= 24'd0;
      res_cout_r  <= 1'b0;
      res_id_r    <= '0;
      op_count_r  <= '0;
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_sum_r   <= add_sum_s;
      res_cout_r  <= add_cout_s;
      res_id_r    <= grant_id_s;
      ptr_r       <= (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
      op_count_r  <= op_count_r + CNT_W'(1);
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign req_ready = req_ready_s;
  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_cout  = res_cout_r;
  assign res_id    = res_id_r;
  assign op_count  = op_count_r;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with a 4-bit counter runs on the same stimulus to exercise wrap-around.

module tb_adder_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*24-1:0] req_a;
  logic [N*24-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic            res_valid;
  logic            res_ready;
  logic [23:0]     res_sum;
  logic            res_cout;
  logic [IW-1:0]   res_id;
  logic [CW-1:0]   op_count;

  logic [N-1:0]    s_ready;
  logic            s_valid;
  logic [23:0]     s_sum;
  logic            s_cout;
  logic [IW-1:0]   s_id;
  logic [3:0]      s_cnt;

  adder_share_arbiter #(.NUM_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .op_count(op_count)
  );

  adder_share_arbiter #(.NUM_REQ(N), .ID_W(IW), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .res_valid(s_valid),
    .res_ready(res_ready), .res_sum(s_sum), .res_cout(s_cout),
    .res_id(s_id), .op_count(s_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_valid;
  logic [23:0] m_sum;
  bit          m_cout;
  int          m_id;
  int          m_ptr;
  int          m_cnt;
  int          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] ref_add(input logic [23:0] a, input logic [23:0] b, input bit cin);
    int hi;
    hi = int'(a[23:16]) + int'(b[23:16]) + int'(cin);
    ref_add = {(hi > 255) || (a[15] && b[15]), 8'(hi % 256), a[15:0] | b[15:0]};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sum = 24'd0; m_cout = 0; m_id = 0; m_ptr = 0; m_cnt = 0; last_acc = -1;
  endtask

  // Called just after a falling edge with inputs set: check, then advance through one rising edge.
  task automatic cycle();
    int g;
    bit free;
    logic [N-1:0] exp_ready;
    logic [24:0] r;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    free = !m_valid || res_ready;
    exp_ready = '0;
    if (g >= 0 && free) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_sum",   32'(res_sum),   32'(m_sum));
    chk("res_cout",  32'(res_cout),  32'(m_cout));
    chk("res_id",    32'(res_id),    32'(m_id));
    chk("op_count",  32'(op_count),  32'(m_cnt % 65536));
    chk("small_ready", 32'(s_ready), 32'(exp_ready));
    chk("small_valid", 32'(s_valid), 32'(m_valid));
    chk("small_sum",   32'(s_sum),   32'(m_sum));
    chk("small_cnt",   32'(s_cnt),   32'(m_cnt % 16));
    r = ref_add(req_a[24*(g < 0 ? 0 : g) +: 24], req_b[24*(g < 0 ? 0 : g) +: 24],
                req_cin[g < 0 ? 0 : g]);
    @(posedge clk);
    if (g >= 0 && free) begin
      m_valid = 1; m_sum = r[23:0]; m_cout = r[24]; m_id = g;
      m_ptr = (g + 1) % N; m_cnt = m_cnt + 1; last_acc = g;
    end else begin
      last_acc = -1;
      if (res_ready) m_valid = 0;
    end
    @(negedge clk);
  endtask

  // New traffic: pending unaccepted requests hold; others are re-rolled with probability pct.
  task automatic refresh(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && last_acc != i)) begin
        req_valid[i] = ($urandom_range(99) < pct);
        req_a[24*i +: 24] = 24'($urandom);
        req_b[24*i +: 24] = 24'($urandom);
        req_cin[i] = 1'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [23:0] held;
    model_reset();
    rst_n = 1'b0; res_ready = 1'b1;
    req_valid = 4'b0001; req_a = '0; req_b = '0; req_cin = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_count", 32'(op_count), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0
    req_a[23:0] = 24'h010000; req_b[23:0] = 24'h020000; req_cin = '0;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_sum",   32'(res_sum),   32'h030000);
    chk("single_cout",  32'(res_cout),  32'h0);
    chk("single_id",    32'(res_id),    32'h0);
    chk("single_count", 32'(op_count),  32'h1);

    // Upper-byte overflow with carry-in from requester 2
    req_valid = 4'b0100; req_a[71:48] = 24'hFF0000; req_b[71:48] = 24'h000000; req_cin = 4'b0100;
    cycle();
    req_valid = '0;
    chk("ovf_sum",  32'(res_sum),  32'h0);
    chk("ovf_cout", 32'(res_cout), 32'h1);
    chk("ovf_id",   32'(res_id),   32'h2);

    // Round-robin with everyone valid and no stall
    do_reset();
    res_ready = 1'b1;
    refresh(100);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_id",    32'(res_id),    32'(k % 4));
      chk("rr_valid", 32'(res_valid), 32'h1);
      refresh(100);
    end
    chk("rr_count", 32'(op_count), 32'd8);

    // Backpressure while requesters 1 and 3 wait
    res_ready = 1'b0; req_valid = 4'b1010;
    held = res_sum;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'h0);
      cycle();
      chk("bp_sum",   32'(res_sum),   32'(held));
      chk("bp_valid", 32'(res_valid), 32'h1);
    end
    res_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h2);
    cycle();
    chk("bp_release_valid", 32'(res_valid), 32'h1);
    chk("bp_release_id",    32'(res_id),    32'h1);

    // Asynchronous reset between edges while a result is held
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(res_valid), 32'h0);
    chk("arst_count", 32'(op_count), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_first_grant", 32'(req_ready), 32'h2);
    cycle();

    // Counter wrap on the 4-bit instance: 17 accepts
    do_reset();
    res_ready = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      req_a[23:0] = 24'($urandom); req_b[23:0] = 24'($urandom);
      cycle();
    end
    chk("wrap_small", 32'(s_cnt), 32'h1);
    chk("wrap_big",   32'(op_count), 32'd17);

    // Randomized traffic with random backpressure
    do_reset();
    req_valid = '0;
    for (int k = 0; k < 3000; k++) begin
      res_ready = ($urandom_range(99) < 70);
      refresh(40);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one instance of the team's 24-bit hybrid adder (`approximate_adder`) among NUM_REQ requesters in the DCT datapath.
- The adder computes an exact carry-lookahead result on bits [23:16] and an OR-AND approximate result on bits [15:0].
- Requesters are served round-robin with valid/ready handshakes.
- Each result goes into a one-entry registered output slot that supports backpressure, tagged with the requester ID, and the block counts completed operations.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..8.
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*24  operand A; requester i occupies [24*i+23:24*i].
- req_b  input  NUM_REQ*24  operand B, same packing as req_a.
- req_cin  input  NUM_REQ  carry-in applied to the precise upper 8 bits.
- res_valid  output  1  result slot holds a valid result.
- res_ready  input  1  downstream accepts the result.
- res_sum  output  24  registered adder sum.
- res_cout  output  1  registered adder carry_out (upper carry OR lower approximate carry).
- res_id  output  ID_W  index of the requester that produced the result.
- op_count  output  CNT_W  number of accepted operations; wraps.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, op_count=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 combinationally while rst_n=0.
- Slot availability: out_free = !res_valid || res_ready.
- Arbitration (combinational):
  - Scan indices ptr, ptr+1, …, ptr+NUM_REQ-1 modulo NUM_REQ; the first with req_valid=1 is granted.
  - req_ready[g] = out_free; all other bits are 0.
  - If no req_valid is set, req_ready=0.
- Adder input: the single shared adder is fed the granted requester's req_a, req_b and req_cin. When there is no grant, its inputs are forced to 0.
- Accept (req_valid[g] && req_ready[g]) on a rising edge:
  - res_sum <= adder sum; res_cout <= adder carry_out; res_id <= g.
  - res_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - op_count <= op_count+1, wrapping from 2^CNT_W-1 to 0.
- Latency: one cycle from accept to res_valid. A requester can be accepted every cycle while downstream holds res_ready=1.
- Simultaneous drain and accept (res_valid=1, res_ready=1, new accept in the same cycle): the slot is overwritten with the new result, res_valid stays 1, and no bubble is inserted.
- Drain only (res_ready=1, no accept): res_valid <= 0; res_sum, res_cout and res_id hold their last values.
- Stall (res_valid=1, res_ready=0):
  - req_ready=0; the slot holds; ptr holds; op_count holds.
- Requester hold rule:
  - A requester must hold req_valid and its operands stable until accepted.
  - The arbiter may change its grant between cycles while stalled, because the grant is recomputed from the current req_valid and ptr.
- Fairness: with all NUM_REQ requesters continuously valid and no stall, grants rotate 0,1,…,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 accepts.
- ptr update: ptr changes only on accept. An idle cycle does not move ptr.
- Reset mid-operation: any held result is discarded (res_valid=0) and the pending handshake is dropped. After rst_n deasserts, arbitration restarts from requester 0.
- Arithmetic: no widening.
  - res_sum is exactly the adder's 24-bit sum.
  - Bits [23:16] are exact (including cin); bits [15:0] are approximate by design.
  - An upper-byte overflow appears only in res_cout.

Test Plan:
- Single request: reset, then req_valid=0001 with A=0x010000, B=0x020000, cin=0. Required: req_ready=0001 the same cycle; next cycle res_valid=1, res_sum=0x030000, res_cout=0, res_id=0, op_count=1.
- Upper overflow with carry-in: requester 2 with A=0xFF0000, B=0x000000, cin=1. Required: res_sum=0x000000, res_cout=1, res_id=2.
- Round-robin: all four valid continuously, res_ready=1, 8 cycles. Required: res_id sequence 0,1,2,3,0,1,2,3; back-to-back res_valid=1; op_count=8.
- Backpressure: result pending with res_ready=0 for 3 cycles while requesters 1 and 3 are valid. Required: req_ready=0 and res_* stable throughout. When res_ready=1, requester 1 is accepted the same cycle and res_valid remains 1.
- Asynchronous reset mid-stream: pull rst_n low between clock edges while res_valid=1. Required: res_valid=0, op_count=0 and req_ready=0 immediately. After release, the first grant goes to the lowest-index valid requester.
- Counter wrap: CNT_W=4, issue 17 accepts. Required: op_count=1.
